// File: rtl/fetch_seq_unit.sv
`default_nettype none
//==============================================================================
// Module   : fetch_seq_unit
// Purpose  : Next-PC sequencer for the front of the pipeline. Holds the fetch
//            PC and applies halt, vectored interrupt, return-from-interrupt,
//            redirect and stall requests in fixed priority. Nested interrupts
//            save their return addresses on a hardware LIFO; overflow,
//            underflow and out-of-range codes raise sticky error flags.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            vec_table       - handler address per interrupt code (entry 0 unused)
//            halt            - halt request
//            interrupt       - interrupt/return request, qualified by int_code
//            int_code        - 0 = return, otherwise vector index
//            pc_override     - redirect request, target = redirect address
//            stall           - hold the PC
//            pc              - current fetch PC (registered)
//            halted          - fetch is halted
//            int_depth       - occupied return-stack entries
//            stack_ovf       - sticky: push attempted with the stack full
//            stack_unf       - sticky: return attempted with the stack empty
//            bad_vec         - sticky: int_code >= NUM_VEC
// Revision : 1.0 - initial release
//==============================================================================
module fetch_seq_unit #(
  parameter int              PC_W        = 16,
  parameter int              NUM_VEC     = 16,
  parameter int              CODE_W      = 4,
  parameter int              RET_DEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter bit              WAKE_ON_INT = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_VEC-1:0][PC_W-1:0]         vec_table,
  input  logic                                 halt,
  input  logic                                 interrupt,
  input  logic [CODE_W-1:0]                    int_code,
  input  logic                                 pc_override,
  input  logic [PC_W-1:0]                      target,
  input  logic                                 stall,
  output logic [PC_W-1:0]                      pc,
  output logic                                 halted,
  output logic [$clog2(RET_DEPTH+1)-1:0]       int_depth,
  output logic                                 stack_ovf,
  output logic                                 stack_unf,
  output logic                                 bad_vec
);

  localparam int c_DEPTH_W = $clog2(RET_DEPTH + 1);
  localparam int c_IDX_W   = (RET_DEPTH > 1) ? $clog2(RET_DEPTH) : 1;

  localparam logic [c_DEPTH_W-1:0] c_RET_DEPTH = c_DEPTH_W'(RET_DEPTH);
  localparam logic [c_DEPTH_W-1:0] c_DEPTH_ONE = c_DEPTH_W'(1);
  localparam logic [PC_W-1:0]      c_PC_ONE    = PC_W'(1);
  // One extra bit so NUM_VEC == 2^CODE_W still fits.
  localparam logic [CODE_W:0]      c_NUM_VEC   = (CODE_W + 1)'(NUM_VEC);

  logic [PC_W-1:0]      r_pc;
  logic                 r_halted;
  logic [c_DEPTH_W-1:0] r_depth;
  logic                 r_ovf, r_unf, r_bad;
  logic [PC_W-1:0]      r_stack [RET_DEPTH];

  logic                 w_code_vec, w_code_ret, w_code_bad;
  logic                 w_full, w_empty;
  logic [PC_W-1:0]      w_vec_pc, w_pc_inc;
  logic [c_IDX_W-1:0]   w_push_idx, w_top_idx;

  logic [PC_W-1:0]      w_pc_nxt;
  logic                 w_halted_nxt;
  logic [c_DEPTH_W-1:0] w_depth_nxt;
  logic                 w_ovf_nxt, w_unf_nxt, w_bad_nxt;
  logic                 w_push;
  logic [PC_W-1:0]      w_push_data;

  // Request decode
  assign w_code_vec = interrupt && (int_code != '0) && ({1'b0, int_code} < c_NUM_VEC);
  assign w_code_ret = interrupt && (int_code == '0);
  assign w_code_bad = interrupt && !({1'b0, int_code} < c_NUM_VEC);
  assign w_full     = (r_depth == c_RET_DEPTH);
  assign w_empty    = (r_depth == '0);
  assign w_pc_inc   = r_pc + c_PC_ONE;
  // Push writes the first free slot; pop reads the most recent entry.
  assign w_push_idx = c_IDX_W'(r_depth);
  assign w_top_idx  = c_IDX_W'(r_depth - c_DEPTH_ONE);

  // Vector lookup as a compare-select so int_code values beyond the table
  // never produce an out-of-range index.
  always_comb begin
    w_vec_pc = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      if (int_code == CODE_W'(i)) w_vec_pc = vec_table[i];
    end
  end

  // Next-state selection
  always_comb begin
    w_pc_nxt     = r_pc;
    w_halted_nxt = r_halted;
    w_depth_nxt  = r_depth;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    w_bad_nxt    = r_bad;
    w_push       = 1'b0;
    w_push_data  = w_pc_inc;

    if (!r_halted) begin
      if (halt) begin
        // Halt wins outright; a coincident interrupt is dropped silently.
        w_halted_nxt = 1'b1;
      end else if (w_code_vec && !w_full) begin
        w_push      = 1'b1;
        w_push_data = w_pc_inc;
        w_pc_nxt    = w_vec_pc;
        w_depth_nxt = r_depth + c_DEPTH_ONE;
      end else if (w_code_ret && !w_empty) begin
        w_pc_nxt    = r_stack[w_top_idx];
        w_depth_nxt = r_depth - c_DEPTH_ONE;
      end else begin
        // Rejected interrupts flag an error and fall through to the
        // lower-priority actions in the same cycle.
        if (w_code_vec) w_ovf_nxt = 1'b1;
        if (w_code_ret) w_unf_nxt = 1'b1;
        if (w_code_bad) w_bad_nxt = 1'b1;
        if (pc_override)  w_pc_nxt = target;
        else if (!stall)  w_pc_nxt = w_pc_inc;
      end
    end else if (WAKE_ON_INT && w_code_vec) begin
      if (!w_full) begin
        // Save the halted PC itself so the return resumes at the halt point.
        w_halted_nxt = 1'b0;
        w_push       = 1'b1;
        w_push_data  = r_pc;
        w_pc_nxt     = w_vec_pc;
        w_depth_nxt  = r_depth + c_DEPTH_ONE;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
      r_depth  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_halted <= w_halted_nxt;
      r_depth  <= w_depth_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
      r_bad    <= w_bad_nxt;
    end
  end

  // Stack contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_stack[w_push_idx] <= w_push_data;
  end

  assign pc        = r_pc;
  assign halted    = r_halted;
  assign int_depth = r_depth;
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;
  assign bad_vec   = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_fetch_seq_unit
// Purpose  : Self-checking bench for fetch_seq_unit: directed scenarios with
//            fixed expected values, then randomized traffic compared each
//            cycle against a behavioural model (queue-based return stack).
// Revision : 1.0 - initial release
//==============================================================================
module tb_fetch_seq_unit;

  localparam int PW = 16;
  localparam int NV = 12;
  localparam int CW = 4;
  localparam int RD = 3;
  localparam int DW = $clog2(RD + 1);
  localparam int PC_MASK = (1 << PW) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NV-1:0][PW-1:0]    vec_table;
  logic                     halt, interrupt, pc_override, stall;
  logic [CW-1:0]            int_code;
  logic [PW-1:0]            target;
  logic [PW-1:0]            pc;
  logic                     halted, stack_ovf, stack_unf, bad_vec;
  logic [DW-1:0]            int_depth;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_pc;
  bit m_halted, m_ovf, m_unf, m_bad;
  int m_stk[$];

  fetch_seq_unit #(
    .PC_W(PW), .NUM_VEC(NV), .CODE_W(CW), .RET_DEPTH(RD),
    .RESET_PC(16'h0000), .WAKE_ON_INT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .vec_table(vec_table), .halt(halt),
    .interrupt(interrupt), .int_code(int_code), .pc_override(pc_override),
    .target(target), .stall(stall), .pc(pc), .halted(halted),
    .int_depth(int_depth), .stack_ovf(stack_ovf), .stack_unf(stack_unf),
    .bad_vec(bad_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model of one clock edge, written from the priority rules directly.
  task automatic model_edge();
    int  code;
    bit  vec_ok, is_ret, is_bad;
    code   = int'(int_code);
    vec_ok = interrupt && code != 0 && code < NV;
    is_ret = interrupt && code == 0;
    is_bad = interrupt && code >= NV;
    if (rst) begin
      m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0; m_bad = 0;
      m_stk.delete();
    end else if (!m_halted) begin
      if (halt) begin
        m_halted = 1;
      end else if (vec_ok && m_stk.size() < RD) begin
        m_stk.push_back((m_pc + 1) & PC_MASK);
        m_pc = int'(vec_table[code]);
      end else if (is_ret && m_stk.size() > 0) begin
        m_pc = m_stk.pop_back();
      end else begin
        if (vec_ok) m_ovf = 1;
        if (is_ret) m_unf = 1;
        if (is_bad) m_bad = 1;
        if (pc_override)  m_pc = int'(target);
        else if (!stall)  m_pc = (m_pc + 1) & PC_MASK;
      end
    end else if (vec_ok) begin
      if (m_stk.size() < RD) begin
        m_stk.push_back(m_pc);
        m_pc = int'(vec_table[code]);
        m_halted = 0;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit h, input bit i, input int c,
                      input bit o, input int t, input bit s, input string tag);
    @(negedge clk);
    rst = r; halt = h; interrupt = i; int_code = CW'(c);
    pc_override = o; target = PW'(t); stall = s;
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".pc"},     32'(pc),        32'(m_pc));
    check({tag, ".halted"}, 32'(halted),    32'(m_halted));
    check({tag, ".depth"},  32'(int_depth), 32'(m_stk.size()));
    check({tag, ".ovf"},    32'(stack_ovf), 32'(m_ovf));
    check({tag, ".unf"},    32'(stack_unf), 32'(m_unf));
    check({tag, ".bad"},    32'(bad_vec),   32'(m_bad));
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    rst = 1; halt = 0; interrupt = 0; int_code = '0;
    pc_override = 0; target = '0; stall = 0;
    for (int k = 0; k < NV; k++) vec_table[k] = PW'($urandom);
    vec_table[1] = 16'h0500;
    vec_table[2] = 16'h0300;
    vec_table[3] = 16'h0100;
    vec_table[5] = 16'h0200;

    // Reset and free-running increment
    step(1, 0, 0, 0, 0, 0, 0, "reset");
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_flags", {29'd0, stack_ovf, stack_unf, bad_vec}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      idle("idle");
      check("idle_pc", 32'(pc), 32'(k));
    end

    // Wrap at the top of the PC range
    step(0, 0, 0, 0, 1, 16'hFFFF, 0, "wrap_set");
    idle("wrap");
    check("wrap_pc", 32'(pc), 32'h0);

    // Nested interrupts and returns
    step(0, 0, 0, 0, 1, 16'h0010, 0, "nest_set");
    step(0, 0, 1, 3, 0, 0, 0, "nest_i3");
    check("nest_i3_pc", 32'(pc), 32'h100);
    check("nest_i3_depth", 32'(int_depth), 32'd1);
    idle("nest_idle");
    idle("nest_idle");
    step(0, 0, 1, 5, 0, 0, 0, "nest_i5");
    check("nest_i5_pc", 32'(pc), 32'h200);
    check("nest_i5_depth", 32'(int_depth), 32'd2);
    step(0, 0, 1, 0, 0, 0, 0, "nest_r1");
    check("nest_r1_pc", 32'(pc), 32'h103);
    step(0, 0, 1, 0, 0, 0, 0, "nest_r2");
    check("nest_r2_pc", 32'(pc), 32'h11);
    check("nest_r2_depth", 32'(int_depth), 32'd0);

    // Overflow falls through to redirect; underflow falls through to increment
    for (int k = 0; k < RD; k++) step(0, 0, 1, 1, 0, 0, 0, "fill");
    step(0, 0, 1, 1, 1, 16'h0040, 0, "ovf");
    check("ovf_pc", 32'(pc), 32'h40);
    check("ovf_flag", 32'(stack_ovf), 32'd1);
    check("ovf_depth", 32'(int_depth), 32'(RD));
    for (int k = 0; k < RD; k++) step(0, 0, 1, 0, 0, 0, 0, "drain");
    check("drain_pc", 32'(pc), 32'h12);
    step(0, 0, 1, 0, 0, 0, 0, "unf");
    check("unf_flag", 32'(stack_unf), 32'd1);
    check("unf_pc", 32'(pc), 32'h13);

    // Halt beats interrupt; vectored interrupt wakes and returns to halt point
    step(0, 0, 0, 0, 1, 16'h0020, 0, "halt_set");
    step(0, 1, 1, 2, 0, 0, 0, "halt");
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'h20);
    check("halt_depth", 32'(int_depth), 32'd0);
    step(0, 0, 0, 0, 1, 16'h0077, 1, "halt_frozen");
    check("halt_frozen_pc", 32'(pc), 32'h20);
    step(0, 0, 1, 2, 0, 0, 0, "wake");
    check("wake_halted", 32'(halted), 32'd0);
    check("wake_pc", 32'(pc), 32'h300);
    step(0, 0, 1, 0, 0, 0, 0, "wake_ret");
    check("wake_ret_pc", 32'(pc), 32'h20);

    // Out-of-range code with stall, then reset mid-nesting while halted
    step(0, 0, 1, 13, 0, 0, 1, "badvec");
    check("badvec_flag", 32'(bad_vec), 32'd1);
    check("badvec_pc", 32'(pc), 32'h20);
    step(0, 0, 1, 1, 0, 0, 0, "pre_rst_int");
    step(0, 1, 0, 0, 0, 0, 0, "pre_rst_halt");
    step(1, 1, 1, 3, 1, 16'h1234, 0, "mid_rst");
    check("mid_rst_pc", 32'(pc), 32'h0);
    check("mid_rst_depth", 32'(int_depth), 32'd0);
    check("mid_rst_state", {28'd0, halted, stack_ovf, stack_unf, bad_vec}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 5) == 0,
           int'($urandom_range(0, PC_MASK)),
           $urandom_range(0, 4) == 0,
           "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_seq_unit.md
Name: fetch_seq_unit

Overview:
Parametrised next-generation PC sequencer for the pipelined core. It keeps the fetch PC and applies halt, vectored interrupts, return-from-interrupt, redirect and stall requests in a fixed priority order. Compared with the single-level fetch unit, it adds a hardware return-address stack for nested interrupts, error flags for stack overflow/underflow and bad vectors, and an optional interrupt wake from halt. It sits at the front of the pipeline and drives the instruction-memory address.

Parameters:
PC_W, 16, PC width in bits; all PC arithmetic is modulo 2^PC_W.
NUM_VEC, 16, number of interrupt codes; code 0 is return-from-interrupt, codes 1..NUM_VEC-1 are vectored.
CODE_W, 4, int_code width; must satisfy 2^CODE_W >= NUM_VEC.
RET_DEPTH, 4, return-stack entries; must be >= 1.
RESET_PC, 0, PC value loaded on reset.
WAKE_ON_INT, 1, 1 = a valid vectored interrupt clears halted; 0 = only reset clears halted.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
vec_table  in  PC_W x NUM_VEC  handler address per code; entry 0 is unused
halt  in  1  halt request
interrupt  in  1  interrupt/return request, qualified by int_code
int_code  in  CODE_W  0 = return, otherwise vector index
pc_override  in  1  redirect request (branch/jump)
target  in  PC_W  redirect address
stall  in  1  hold the PC
pc  out  PC_W  current fetch PC
halted  out  1  fetch is halted
int_depth  out  clog2(RET_DEPTH+1)  number of occupied stack entries
stack_ovf  out  1  sticky error: push attempted while the stack was full
stack_unf  out  1  sticky error: return attempted while the stack was empty
bad_vec  out  1  sticky error: int_code >= NUM_VEC

Behaviour:
- One clock; reset is synchronous and active-high (rst, sampled on posedge clk).
- Reset state: pc=RESET_PC, halted=0, int_depth=0, stack_ovf=0, stack_unf=0, bad_vec=0. Stack contents are don't-care.
- Reset in any cycle, including mid-nesting or while halted, overrides every other input.
- All state updates on posedge clk. Outputs are registered, so a request sampled in cycle N is visible on pc in cycle N+1 (one-cycle latency).
- Priority when not halted, highest first; exactly one action per cycle:
  1. halt: halted<=1, pc holds.
  2. interrupt with int_code in 1..NUM_VEC-1 and int_depth<RET_DEPTH: push pc+1, pc<=vec_table[int_code], int_depth+1.
  3. interrupt with int_code=0 and int_depth>0: pc<=top of stack, pop, int_depth-1.
  4. pc_override: pc<=target.
  5. stall: pc holds.
  6. Otherwise pc<=pc+1. Wrap is 2^PC_W-1 -> 0.
- Rejected interrupts fall through to the next lower-priority action in the same cycle:
  - Vectored code with the stack full: stack_ovf<=1, vector not taken.
  - Code 0 with the stack empty: stack_unf<=1.
  - int_code>=NUM_VEC: bad_vec<=1.
- Error flags are sticky until rst.
- Halted state:
  - pc frozen; pc_override, stall and code 0 are ignored.
  - WAKE_ON_INT=1 and a valid vectored interrupt with the stack not full: halted<=0, push pc (the halted PC, so return resumes at the halt point), pc<=vector.
  - A full stack in that case sets stack_ovf and halted stays 1.
  - halt reasserted while halted: no effect.
- Simultaneous halt+interrupt while running: halt wins, interrupt is dropped and no flag is set.
- Stack is LIFO, indexed by int_depth. A push and a pop never occur in the same cycle.

Test Plan:
- Reset, then 4 idle cycles -> pc=0,1,2,3,4; halted=0; all flags 0.
- PC_W=4, pc=15, idle cycle -> pc=0 (wrap).
- Nesting: pc=0x10, int code 3 (vec 0x100) -> pc=0x100, depth=1. At pc=0x102, int code 5 (vec 0x200) -> pc=0x200, depth=2. Code 0 -> pc=0x103, depth=1. Code 0 -> pc=0x11, depth=0.
- RET_DEPTH=2, depth=2, int code 1 with pc_override target=0x40 same cycle -> pc=0x40, stack_ovf=1, depth=2. Code 0 at depth 0 -> stack_unf=1, pc increments.
- pc=0x20, halt+interrupt code 2 same cycle -> halted=1, pc=0x20, depth=0. Next cycle int code 2 (vec 0x300), WAKE_ON_INT=1 -> halted=0, pc=0x300. Code 0 -> pc=0x20.
- NUM_VEC=8, int_code=9 with stall -> bad_vec=1, pc holds. Assert rst while depth=1 and halted -> pc=RESET_PC, depth=0, all flags 0.
